cpu_execute_mc: RTL and testbench
=================================

CPU_EXECUTE_MC -- requirements
Module: cpu_execute_mc

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning ALU datapath width (DW >= 4).
REQ-002 The block SHALL have parameter TW, default 3, meaning stack-entry tag bits; stack entry width is DW+TW.
REQ-003 The block SHALL have parameter PW, default 32, meaning PC width (PW <= DW).
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  clock, rising edge
  rst_b  in  1  reset, asynchronous, active-low
  in_valid_2a  in  1  stage-2 instruction present
  stall_2a  out  1  upstream hold request, combinational
  op_2a  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 EQ, 7 MUL
  sel_left_2a  in  2  0 imm, 1 top0, 2 topn, 3 pc (zero-extended)
  sel_right_2a  in  2  0 imm, 1 top0, 2 topn, 3 r1_3a[DW-1:0]
  imm_2a  in  DW  immediate
  pc_2a  in  PW  instruction PC
  top0_2a  in  DW+TW  stack top entry
  topn_2a  in  DW+TW  stack entry n
  cap_r0_2a  in  1  capture top0_2a into r0_3a
  cap_r1_2a  in  1  capture topn_2a into r1_3a
  kill_4a  in  1  squash from stage 4
  out_valid_3a  out  1  result valid, one-cycle pulse
  alu_out_3a  out  DW  result
  alu_cond_3a  out  1  condition flag
  pc_3a  out  PW  PC of the completed instruction
  r0_3a  out  DW+TW  saved stack entry 0
  r1_3a  out  DW+TW  saved stack entry n

Function
REQ-005 The block SHALL use an FSM with states IDLE and MUL.
REQ-006 In IDLE with in_valid_2a=1, kill_4a=0, and op_2a != MUL, the next edge SHALL register alu_out_3a, alu_cond_3a, and pc_3a, and set out_valid_3a=1 (latency 1).
REQ-007 ADD and SUB SHALL wrap modulo 2^DW.
REQ-008 The cond flag SHALL be: ADD, SUB, AND, OR, XOR -> result==0; SLT -> signed left<right, with alu_out = zero-extended cond; EQ -> left==right, with alu_out = zero-extended cond.
REQ-009 In IDLE with in_valid_2a=1, kill_4a=0, and op_2a=MUL, the block SHALL latch both operands and pc_2a, clear the accumulator and counter, and enter MUL (edge E0).
REQ-010 In MUL, each edge SHALL process one multiplier bit (shift-add) and increment the counter; edge E_DW SHALL load alu_out_3a with the low DW bits of the product, set alu_cond_3a = (alu_out_3a==0), set out_valid_3a=1, and return to IDLE.
REQ-011 stall_2a SHALL equal !kill_4a & ((IDLE & in_valid_2a & op_2a==MUL) | (MUL & counter != DW-1)), giving DW stalled cycles per MUL.
REQ-012 In MUL, the block SHALL ignore the stage-2 inputs, including cap_r0_2a and cap_r1_2a.
REQ-013 kill_4a=1 in any state SHALL force IDLE at the next edge, give out_valid_3a=0, accept nothing, and block r0/r1 capture; alu_out_3a and pc_3a SHALL hold.
REQ-014 In IDLE with in_valid_2a=1 and kill_4a=0, a set cap_r0_2a/cap_r1_2a SHALL load r0_3a/r1_3a at the next edge; otherwise r0_3a and r1_3a SHALL hold.
REQ-015 A right-operand select of r1_3a SHALL read the registered value before any same-edge update; no bypass is provided.
REQ-016 out_valid_3a SHALL be 0 on every cycle not covered by REQ-006 or REQ-010.
REQ-017 in_valid_2a=0 SHALL cause no state change other than out_valid_3a=0.

Reset
REQ-018 While rst_b=0, all outputs SHALL be 0, state SHALL be IDLE, and counter, accumulator, and operand latches SHALL be 0, immediately and independent of clk.
REQ-019 Assertion of rst_b during MUL SHALL abort the operation with no out_valid_3a pulse after release.

Verification
REQ-020 The bench SHALL cover: ADD, sel_left imm=5, sel_right top0=7 -> next cycle out_valid_3a=1, alu_out_3a=12, cond=0.
REQ-021 The bench SHALL cover: DW=32 MUL 6*7 -> stall_2a high exactly 32 cycles, out_valid_3a at E32, alu_out_3a=42, pc_3a=latched PC.
REQ-022 The bench SHALL cover: DW=16 MUL 0x0100*0x0100 -> alu_out_3a=0x0000, cond=1; SUB 0-1 -> 0xFFFF.
REQ-023 The bench SHALL cover: kill_4a at counter=10 of a MUL -> IDLE next edge, no out_valid_3a, stall_2a=0; a following ADD completes normally.
REQ-024 The bench SHALL cover: cap_r1_2a with topn=0x5_0000_0009 (TW=3), then next instruction ADD imm 1 + r1 -> alu_out_3a=10; the same capture with kill_4a=1 -> r1_3a unchanged.
REQ-025 The bench SHALL cover: rst_b pulsed low mid-MUL -> all outputs 0 asynchronously, no out_valid_3a after release.

Source files
------------

// File: rtl/cpu_execute_mc.sv
// cpu_execute_mc: execute stage. Single-cycle ALU operations complete one
// edge after acceptance; MUL runs as a bit-serial shift-add multiplier and
// holds stage 2 for DW cycles. Saved stack entries r0/r1 are captured here.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepting stage-2 instructions; single-cycle ops finish here
// MUL   | shift-add multiply running, one multiplier bit per edge
module cpu_execute_mc #(
   parameter int DW = 32,
   parameter int TW = 3,
   parameter int PW = 32
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              in_valid_2a,
   output logic              stall_2a,
   input  logic [2:0]        op_2a,
   input  logic [1:0]        sel_left_2a,
   input  logic [1:0]        sel_right_2a,
   input  logic [DW-1:0]     imm_2a,
   input  logic [PW-1:0]     pc_2a,
   input  logic [DW+TW-1:0]  top0_2a,
   input  logic [DW+TW-1:0]  topn_2a,
   input  logic              cap_r0_2a,
   input  logic              cap_r1_2a,
   input  logic              kill_4a,
   output logic              out_valid_3a,
   output logic [DW-1:0]     alu_out_3a,
   output logic              alu_cond_3a,
   output logic [PW-1:0]     pc_3a,
   output logic [DW+TW-1:0]  r0_3a,
   output logic [DW+TW-1:0]  r1_3a
);

   localparam int CW = $clog2(DW + 1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;
   localparam logic [2:0] OP_EQ  = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [DW-1:0]      acc_q;
   logic [DW-1:0]      mcand_q;
   logic [DW-1:0]      mplier_q;
   logic [PW-1:0]      mpc_q;
   logic               valid_q;
   logic [DW-1:0]      alu_q;
   logic               cond_q;
   logic [PW-1:0]      pc_q;
   logic [DW+TW-1:0]   r0_q;
   logic [DW+TW-1:0]   r1_q;

   logic [DW-1:0]      pc_ext;
   logic [DW-1:0]      left_d;
   logic [DW-1:0]      right_d;
   logic [DW-1:0]      res_d;
   logic               cond_d;
   logic [DW-1:0]      acc_d;
   logic               last_bit;

   assign last_bit = (cnt_q == CW'(DW - 1));

   // Operand selection and single-cycle ALU; r1 is read from its register,
   // so a same-edge capture never bypasses into the operand.
   always_comb begin
      pc_ext = '0;
      pc_ext[PW-1:0] = pc_2a;
      unique case (sel_left_2a)
         2'd0:    left_d = imm_2a;
         2'd1:    left_d = top0_2a[DW-1:0];
         2'd2:    left_d = topn_2a[DW-1:0];
         default: left_d = pc_ext;
      endcase
      unique case (sel_right_2a)
         2'd0:    right_d = imm_2a;
         2'd1:    right_d = top0_2a[DW-1:0];
         2'd2:    right_d = topn_2a[DW-1:0];
         default: right_d = r1_q[DW-1:0];
      endcase
      res_d = '0;
      unique case (op_2a)
         OP_ADD:  res_d = left_d + right_d;
         OP_SUB:  res_d = left_d - right_d;
         OP_AND:  res_d = left_d & right_d;
         OP_OR:   res_d = left_d | right_d;
         OP_XOR:  res_d = left_d ^ right_d;
         OP_SLT:  res_d[0] = ($signed(left_d) < $signed(right_d));
         OP_EQ:   res_d[0] = (left_d == right_d);
         default: res_d = '0;
      endcase
      if (op_2a == OP_SLT || op_2a == OP_EQ) begin
         cond_d = res_d[0];
      end else begin
         cond_d = (res_d == '0);
      end
   end

   // One shift-add step: add the multiplicand when the current multiplier bit is set.
   always_comb begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   // Hold upstream while a MUL is being accepted or is not yet on its last bit.
   assign stall_2a = rst_b & ~kill_4a &
                     (((state_q == S_IDLE) & in_valid_2a & (op_2a == OP_MUL)) |
                      ((state_q == S_MUL) & ~last_bit));

   // Execute FSM with registered result, flag, PC and saved stack entries.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         mpc_q    <= '0;
         valid_q  <= 1'b0;
         alu_q    <= '0;
         cond_q   <= 1'b0;
         pc_q     <= '0;
         r0_q     <= '0;
         r1_q     <= '0;
      end else begin
         valid_q <= 1'b0;
         if (kill_4a) begin
            state_q <= S_IDLE;
         end else if (state_q == S_IDLE) begin
            if (in_valid_2a) begin
               if (cap_r0_2a) r0_q <= top0_2a;
               if (cap_r1_2a) r1_q <= topn_2a;
               if (op_2a == OP_MUL) begin
                  mcand_q  <= left_d;
                  mplier_q <= right_d;
                  mpc_q    <= pc_2a;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= S_MUL;
               end else begin
                  valid_q <= 1'b1;
                  alu_q   <= res_d;
                  cond_q  <= cond_d;
                  pc_q    <= pc_2a;
               end
            end
         end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (last_bit) begin
               valid_q <= 1'b1;
               alu_q   <= acc_d;
               cond_q  <= (acc_d == '0);
               pc_q    <= mpc_q;
               state_q <= S_IDLE;
            end
         end
      end
   end

   assign out_valid_3a = valid_q;
   assign alu_out_3a   = alu_q;
   assign alu_cond_3a  = cond_q;
   assign pc_3a        = pc_q;
   assign r0_3a        = r0_q;
   assign r1_3a        = r1_q;

endmodule

// File: tb/tb_cpu_execute_mc.sv
// Bench for cpu_execute_mc: a DW=32 instance for most scenarios and a DW=16
// instance for the narrow-width wrap cases. Expected results are queued when
// an instruction is issued and popped when out_valid_3a is seen.
module tb_cpu_execute_mc;

   typedef struct packed {
      logic [31:0] alu;
      logic        cond;
      logic [31:0] pc;
   } exp_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [1:0]  sl;
      logic [1:0]  sr;
      logic [31:0] imm;
      logic [31:0] pcv;
      logic [34:0] t0;
      logic [34:0] tn;
   } vec_t;

   logic clk;
   logic rst_b;

   logic        in_valid, stall, cap0, cap1, kill, ov, cond;
   logic [2:0]  op;
   logic [1:0]  sl, sr;
   logic [31:0] imm, pc, alu, pco;
   logic [34:0] top0, topn, r0, r1;

   logic        b_in_valid, b_stall, b_cap0, b_cap1, b_kill, b_ov, b_cond;
   logic [2:0]  b_op;
   logic [1:0]  b_sl, b_sr;
   logic [15:0] b_imm, b_pc, b_alu, b_pco;
   logic [18:0] b_top0, b_topn, b_r0, b_r1;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   exp_t sb16[$];
   exp_t e;
   logic [31:0] last_alu, last_pc;
   logic [34:0] r1_model;

   cpu_execute_mc #(.DW(32), .TW(3), .PW(32)) dut (
      .clk(clk), .rst_b(rst_b), .in_valid_2a(in_valid), .stall_2a(stall),
      .op_2a(op), .sel_left_2a(sl), .sel_right_2a(sr), .imm_2a(imm),
      .pc_2a(pc), .top0_2a(top0), .topn_2a(topn), .cap_r0_2a(cap0),
      .cap_r1_2a(cap1), .kill_4a(kill), .out_valid_3a(ov), .alu_out_3a(alu),
      .alu_cond_3a(cond), .pc_3a(pco), .r0_3a(r0), .r1_3a(r1)
   );

   cpu_execute_mc #(.DW(16), .TW(3), .PW(16)) dut16 (
      .clk(clk), .rst_b(rst_b), .in_valid_2a(b_in_valid), .stall_2a(b_stall),
      .op_2a(b_op), .sel_left_2a(b_sl), .sel_right_2a(b_sr), .imm_2a(b_imm),
      .pc_2a(b_pc), .top0_2a(b_top0), .topn_2a(b_topn), .cap_r0_2a(b_cap0),
      .cap_r1_2a(b_cap1), .kill_4a(b_kill), .out_valid_3a(b_ov), .alu_out_3a(b_alu),
      .alu_cond_3a(b_cond), .pc_3a(b_pco), .r0_3a(b_r0), .r1_3a(b_r1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(logic [2:0] o, logic [31:0] l, logic [31:0] r, logic [31:0] p);
      exp_t x;
      x.pc = p;
      case (o)
         3'd0:    x.alu = l + r;
         3'd1:    x.alu = l - r;
         3'd2:    x.alu = l & r;
         3'd3:    x.alu = l | r;
         3'd4:    x.alu = l ^ r;
         3'd5:    x.alu = ($signed(l) < $signed(r)) ? 32'd1 : 32'd0;
         3'd6:    x.alu = (l == r) ? 32'd1 : 32'd0;
         default: x.alu = l * r;
      endcase
      x.cond = (o == 3'd5 || o == 3'd6) ? x.alu[0] : (x.alu == 32'd0);
      return x;
   endfunction

   function automatic logic [31:0] pick(logic [1:0] s, logic [31:0] i, logic [34:0] t0,
                                        logic [34:0] tn, logic [31:0] last);
      case (s)
         2'd0:    return i;
         2'd1:    return t0[31:0];
         2'd2:    return tn[31:0];
         default: return last;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      in_valid = 0; op = 0; sl = 0; sr = 0; imm = 0; pc = 0; top0 = 0; topn = 0;
      cap0 = 0; cap1 = 0; kill = 0;
      b_in_valid = 0; b_op = 0; b_sl = 0; b_sr = 0; b_imm = 0; b_pc = 0; b_top0 = 0;
      b_topn = 0; b_cap0 = 0; b_cap1 = 0; b_kill = 0;
   endtask

   task automatic test_reset();
      idle_in();
      rst_b = 0;
      in_valid = 1; op = 3'd7; b_in_valid = 1; b_op = 3'd7;
      #3;
      checks++;
      if ({ov, alu, cond, pco, r0, r1, stall} !== '0) begin
         errors++;
         $display("FAIL reset_outputs32 got ov=%b alu=%h cond=%b pc=%h r0=%h r1=%h stall=%b expected all 0",
                  ov, alu, cond, pco, r0, r1, stall);
      end
      checks++;
      if ({b_ov, b_alu, b_cond, b_pco, b_r0, b_r1, b_stall} !== '0) begin
         errors++;
         $display("FAIL reset_outputs16 got ov=%b alu=%h stall=%b expected all 0", b_ov, b_alu, b_stall);
      end
      idle_in();
      step();
      rst_b = 1;
      r1_model = '0;
      last_alu = '0;
      last_pc = '0;
   endtask

   task automatic test_alu();
      vec_t v [10];
      logic [31:0] l, r;
      v[0] = '{3'd0, 2'd0, 2'd1, 32'd5,         32'h10, 35'h7,           35'h0};
      v[1] = '{3'd1, 2'd3, 2'd0, 32'h100,       32'h100, 35'h0,          35'h0};
      v[2] = '{3'd2, 2'd1, 2'd2, 32'd0,         32'h14, 35'h5_0000_F0F0, 35'h2_0000_0FF0};
      v[3] = '{3'd3, 2'd2, 2'd1, 32'd0,         32'h18, 35'h1,           35'h6_0000_0002};
      v[4] = '{3'd4, 2'd0, 2'd0, 32'hDEAD,      32'h1C, 35'h0,           35'h0};
      v[5] = '{3'd5, 2'd1, 2'd0, 32'd1,         32'h20, 35'h7_FFFF_FFFF, 35'h0};
      v[6] = '{3'd5, 2'd0, 2'd2, 32'd1,         32'h24, 35'h0,           35'h0_FFFF_FFFF};
      v[7] = '{3'd6, 2'd0, 2'd1, 32'h55,        32'h28, 35'h3_0000_0055, 35'h0};
      v[8] = '{3'd0, 2'd0, 2'd2, 32'hFFFF_FFFF, 32'h2C, 35'h0,           35'h1};
      v[9] = '{3'd1, 2'd0, 2'd2, 32'd3,         32'h30, 35'h0,           35'h5};
      for (int k = 0; k < 10; k++) begin
         op = v[k].op; sl = v[k].sl; sr = v[k].sr; imm = v[k].imm;
         pc = v[k].pcv; top0 = v[k].t0; topn = v[k].tn; in_valid = 1;
         l = pick(v[k].sl, v[k].imm, v[k].t0, v[k].tn, v[k].pcv);
         r = pick(v[k].sr, v[k].imm, v[k].t0, v[k].tn, r1_model[31:0]);
         sb.push_back(model(v[k].op, l, r, v[k].pcv));
         #1;
         checks++;
         if (stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_no_stall vec %0d got %b expected 0", k, stall);
         end
         step();
         checks++;
         if (ov !== 1'b1) begin
            errors++;
            $display("FAIL alu_valid vec %0d got %b expected 1", k, ov);
         end
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL alu_sb_empty vec %0d", k);
         end else begin
            e = sb.pop_front();
            checks++;
            if (alu !== e.alu || cond !== e.cond || pco !== e.pc) begin
               errors++;
               $display("FAIL alu_result vec %0d got alu=%h cond=%b pc=%h expected alu=%h cond=%b pc=%h",
                        k, alu, cond, pco, e.alu, e.cond, e.pc);
            end
            last_alu = e.alu;
            last_pc = e.pc;
         end
      end
      idle_in();
      step();
      checks++;
      if (ov !== 1'b0 || alu !== last_alu || pco !== last_pc) begin
         errors++;
         $display("FAIL idle_hold got ov=%b alu=%h pc=%h expected ov=0 alu=%h pc=%h",
                  ov, alu, pco, last_alu, last_pc);
      end
   endtask

   task automatic test_mul();
      int n_stall, edges;
      bit got;
      op = 3'd7; sl = 2'd0; imm = 32'd6; sr = 2'd1; top0 = 35'h7; pc = 32'hABC; in_valid = 1;
      sb.push_back(model(3'd7, 32'd6, 32'd7, 32'hABC));
      #1;
      n_stall = 0; edges = 0; got = 0;
      while (!got && edges < 100) begin
         if (stall) n_stall++;
         else in_valid = 0;
         step();
         edges++;
         if (edges == 1) begin
            imm = 32'd1000; top0 = 35'h9; cap1 = 1; topn = 35'h3_0000_0077;
         end
         if (ov) got = 1;
      end
      idle_in();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL mul_timeout got no out_valid within %0d cycles expected one", edges);
      end
      checks++;
      if (edges != 33 || n_stall != 32) begin
         errors++;
         $display("FAIL mul_timing got edges=%0d stall_cycles=%0d expected 33 and 32", edges, n_stall);
      end
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL mul_sb_empty");
      end else begin
         e = sb.pop_front();
         checks++;
         if (alu !== e.alu || cond !== e.cond || pco !== e.pc) begin
            errors++;
            $display("FAIL mul_result got alu=%h cond=%b pc=%h expected alu=%h cond=%b pc=%h",
                     alu, cond, pco, e.alu, e.cond, e.pc);
         end
         last_alu = e.alu;
         last_pc = e.pc;
      end
      checks++;
      if (r1 !== r1_model) begin
         errors++;
         $display("FAIL mul_ignores_cap got r1=%h expected %h", r1, r1_model);
      end
   endtask

   task automatic test_kill_mul();
      int n_ov;
      op = 3'd7; sl = 2'd0; imm = 32'd3; sr = 2'd1; top0 = 35'h5; pc = 32'h200; in_valid = 1;
      step();
      idle_in();
      n_ov = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (ov) n_ov++;
      end
      checks++;
      if (n_ov != 0 || stall !== 1'b1) begin
         errors++;
         $display("FAIL kill_pre got pulses=%0d stall=%b expected 0 and 1", n_ov, stall);
      end
      kill = 1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL kill_stall got %b expected 0", stall);
      end
      step();
      kill = 0;
      #1;
      checks++;
      if (ov !== 1'b0 || alu !== last_alu || pco !== last_pc || stall !== 1'b0) begin
         errors++;
         $display("FAIL kill_effect got ov=%b alu=%h pc=%h stall=%b expected 0 %h %h 0",
                  ov, alu, pco, stall, last_alu, last_pc);
      end
      op = 3'd0; sl = 2'd0; sr = 2'd0; imm = 32'd1; pc = 32'h210; in_valid = 1;
      sb.push_back(model(3'd0, 32'd1, 32'd1, 32'h210));
      step();
      idle_in();
      checks++;
      if (ov !== 1'b1) begin
         errors++;
         $display("FAIL kill_after_add_valid got %b expected 1", ov);
      end
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL kill_sb_empty");
      end else begin
         e = sb.pop_front();
         checks++;
         if (alu !== e.alu || cond !== e.cond || pco !== e.pc) begin
            errors++;
            $display("FAIL kill_after_add got alu=%h cond=%b pc=%h expected alu=%h cond=%b pc=%h",
                     alu, cond, pco, e.alu, e.cond, e.pc);
         end
         last_alu = e.alu;
         last_pc = e.pc;
      end
   endtask

   task automatic test_capture();
      op = 3'd0; sl = 2'd0; sr = 2'd0; imm = 32'd0; pc = 32'h400;
      top0 = 35'h2_0000_0003; topn = 35'h5_0000_0009; cap0 = 1; cap1 = 1; in_valid = 1;
      sb.push_back(model(3'd0, 32'd0, 32'd0, 32'h400));
      step();
      r1_model = 35'h5_0000_0009;
      checks++;
      if (r0 !== 35'h2_0000_0003 || r1 !== r1_model) begin
         errors++;
         $display("FAIL cap_load got r0=%h r1=%h expected 200000003 %h", r0, r1, r1_model);
      end
      if (sb.size() == 0 || ov !== 1'b1) begin
         errors++;
         $display("FAIL cap_first_missing got ov=%b", ov);
      end else begin
         e = sb.pop_front();
         checks++;
         if (alu !== e.alu || cond !== e.cond || pco !== e.pc) begin
            errors++;
            $display("FAIL cap_first got alu=%h cond=%b expected alu=%h cond=%b", alu, cond, e.alu, e.cond);
         end
      end
      sl = 2'd0; imm = 32'd1; sr = 2'd3; cap0 = 0; cap1 = 1; topn = 35'h1_0000_0020; pc = 32'h404;
      sb.push_back(model(3'd0, 32'd1, r1_model[31:0], 32'h404));
      step();
      r1_model = 35'h1_0000_0020;
      if (sb.size() == 0 || ov !== 1'b1) begin
         errors++;
         $display("FAIL cap_r1_add_missing got ov=%b", ov);
      end else begin
         e = sb.pop_front();
         checks++;
         if (alu !== e.alu || pco !== e.pc) begin
            errors++;
            $display("FAIL cap_r1_add got alu=%h pc=%h expected alu=%h pc=%h", alu, pco, e.alu, e.pc);
         end
         last_alu = e.alu;
         last_pc = e.pc;
      end
      checks++;
      if (r1 !== r1_model) begin
         errors++;
         $display("FAIL cap_r1_update got %h expected %h", r1, r1_model);
      end
      kill = 1; cap0 = 1; cap1 = 1; top0 = 35'h7_1111_1111; topn = 35'h7_FFFF_FFFF;
      sr = 2'd0; pc = 32'h408;
      step();
      idle_in();
      checks++;
      if (ov !== 1'b0 || r0 !== 35'h2_0000_0003 || r1 !== r1_model || alu !== last_alu) begin
         errors++;
         $display("FAIL cap_killed got ov=%b r0=%h r1=%h alu=%h expected 0 200000003 %h %h",
                  ov, r0, r1, alu, r1_model, last_alu);
      end
   endtask

   task automatic test_mul16();
      int edges;
      bit got;
      b_op = 3'd7; b_sl = 2'd0; b_imm = 16'h0100; b_sr = 2'd1; b_top0 = 19'h0100;
      b_pc = 16'h0050; b_in_valid = 1;
      sb16.push_back('{32'h0, 1'b1, 32'h50});
      #1;
      edges = 0; got = 0;
      while (!got && edges < 60) begin
         if (!b_stall) b_in_valid = 0;
         step();
         edges++;
         if (b_ov) got = 1;
      end
      checks++;
      if (!got || edges != 17) begin
         errors++;
         $display("FAIL mul16_timing got valid=%b edges=%0d expected 1 and 17", got, edges);
      end
      if (sb16.size() == 0) begin
         errors++;
         $display("FAIL mul16_sb_empty");
      end else begin
         e = sb16.pop_front();
         checks++;
         if (b_alu !== e.alu[15:0] || b_cond !== e.cond || b_pco !== e.pc[15:0]) begin
            errors++;
            $display("FAIL mul16_result got alu=%h cond=%b pc=%h expected alu=%h cond=%b",
                     b_alu, b_cond, b_pco, e.alu[15:0], e.cond);
         end
      end
      b_op = 3'd1; b_sl = 2'd0; b_imm = 16'h0; b_sr = 2'd2; b_topn = 19'h1; b_pc = 16'h54; b_in_valid = 1;
      sb16.push_back('{32'hFFFF, 1'b0, 32'h54});
      step();
      b_in_valid = 0;
      checks++;
      if (b_ov !== 1'b1 || sb16.size() == 0) begin
         errors++;
         $display("FAIL sub16_valid got %b expected 1", b_ov);
      end else begin
         e = sb16.pop_front();
         if (b_alu !== e.alu[15:0] || b_cond !== e.cond || b_pco !== e.pc[15:0]) begin
            errors++;
            $display("FAIL sub16_result got alu=%h cond=%b expected alu=%h cond=%b",
                     b_alu, b_cond, e.alu[15:0], e.cond);
         end
      end
   endtask

   task automatic test_reset_mid_mul();
      int n_ov;
      op = 3'd7; sl = 2'd0; imm = 32'd9; sr = 2'd1; top0 = 35'h9; pc = 32'h300; in_valid = 1;
      step();
      in_valid = 0;
      repeat (5) step();
      #2;
      rst_b = 0;
      #1;
      checks++;
      if ({ov, alu, cond, pco, r0, r1, stall} !== '0 || {b_ov, b_alu, b_cond, b_pco} !== '0) begin
         errors++;
         $display("FAIL async_reset_mid_mul got ov=%b alu=%h pc=%h r0=%h r1=%h stall=%b b_alu=%h expected all 0",
                  ov, alu, pco, r0, r1, stall, b_alu);
      end
      in_valid = 1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall got %b expected 0", stall);
      end
      idle_in();
      step();
      step();
      rst_b = 1;
      r1_model = '0;
      n_ov = 0;
      repeat (40) begin
         step();
         if (ov) n_ov++;
      end
      checks++;
      if (n_ov != 0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort got pulses=%0d stall=%b expected 0 and 0", n_ov, stall);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mul();
      test_kill_mul();
      test_capture();
      test_mul16();
      test_reset_mid_mul();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
